// File: rtl/float2int32_seq.sv
// Sequential IEEE-754 single-precision to signed 32-bit integer converter.
// Truncates toward zero, saturates on overflow/inf, one shift bit per cycle.
`timescale 1ns/1ps
module float2int32_seq #(
    parameter logic [31:0] SAT_POS = 32'h7FFFFFFF,
    parameter logic [31:0] SAT_NEG = 32'h80000000,
    parameter logic [31:0] NAN_VAL = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        val,
    input  logic [31:0] in_f32,
    output logic        busy,
    output logic        rdy,
    output logic [31:0] out_int,
    output logic        ovf,
    output logic        nan
);

    localparam int unsigned W  = 32;
    localparam int unsigned EW = 8;
    localparam int unsigned FW = 23;
    localparam int unsigned NW = 5;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_NAN, CLS_SAT} cls_t;

    state_t          r_state;
    cls_t            r_cls;
    logic            r_sign;
    logic            r_left;
    logic            r_sat_ovf;
    logic [W-1:0]    r_mag;
    logic [NW-1:0]   r_n;
    logic            r_busy;
    logic            r_rdy;
    logic [W-1:0]    r_out;
    logic            r_ovf;
    logic            r_nan;

    logic [EW-1:0]   w_exp;
    logic [FW-1:0]   w_frac;
    cls_t            w_cls;
    logic [NW-1:0]   w_n;
    logic            w_left;
    logic            w_sat_ovf;
    logic [W-1:0]    w_res;

    assign w_exp  = in_f32[30:23];
    assign w_frac = in_f32[22:0];

    // Classify the incoming operand; shift count is |E - 150| (i.e. |e - 23|)
    always_comb begin
        w_cls     = CLS_NUM;
        w_n       = '0;
        w_left    = 1'b0;
        w_sat_ovf = 1'b1;
        if (w_exp == 8'hFF && w_frac != '0) begin
            w_cls = CLS_NAN;
        end else if (w_exp == 8'hFF) begin
            w_cls = CLS_SAT;
        end else if (w_exp >= 8'd158) begin
            w_cls     = CLS_SAT;
            w_sat_ovf = (in_f32 != 32'hCF000000);
        end else if (w_exp < 8'd127) begin
            w_cls = CLS_ZERO;
        end else if (w_exp >= 8'd150) begin
            w_left = 1'b1;
            w_n    = NW'(w_exp - 8'd150);
        end else begin
            w_n    = NW'(8'd150 - w_exp);
        end
    end

    // Final value loaded on the edge entering DONE
    always_comb begin
        w_res = '0;
        case (r_cls)
            CLS_NAN:  w_res = NAN_VAL;
            CLS_SAT:  w_res = r_sign ? SAT_NEG : SAT_POS;
            CLS_ZERO: w_res = '0;
            default:  w_res = r_sign ? (W'(0) - r_mag) : r_mag;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cls     <= CLS_ZERO;
            r_sign    <= 1'b0;
            r_left    <= 1'b0;
            r_sat_ovf <= 1'b0;
            r_mag     <= '0;
            r_n       <= '0;
            r_busy    <= 1'b0;
            r_rdy     <= 1'b0;
            r_out     <= '0;
            r_ovf     <= 1'b0;
            r_nan     <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (val) begin
                        r_sign    <= in_f32[31];
                        r_mag     <= {8'd0, 1'b1, w_frac};
                        r_cls     <= w_cls;
                        r_n       <= w_n;
                        r_left    <= w_left;
                        r_sat_ovf <= w_sat_ovf;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_n != '0) begin
                        r_mag <= r_left ? (r_mag << 1) : (r_mag >> 1);
                        r_n   <= r_n - NW'(1);
                    end else begin
                        r_out   <= w_res;
                        r_ovf   <= (r_cls == CLS_SAT) && r_sat_ovf;
                        r_nan   <= (r_cls == CLS_NAN);
                        r_rdy   <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign rdy     = r_rdy;
    assign out_int = r_out;
    assign ovf     = r_ovf;
    assign nan     = r_nan;

endmodule

// File: tb/tb_float2int32_seq.sv
// Directed-vector bench for float2int32_seq with hand-computed results.
`timescale 1ns/1ps
module tb_float2int32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        val;
    logic [31:0] in_f32;
    logic        busy;
    logic        rdy;
    logic [31:0] out_int;
    logic        ovf;
    logic        nan;

    int n_vec = 0;
    int n_err = 0;

    float2int32_seq dut (
        .clk     (clk),
        .rst     (rst),
        .val     (val),
        .in_f32  (in_f32),
        .busy    (busy),
        .rdy     (rdy),
        .out_int (out_int),
        .ovf     (ovf),
        .nan     (nan)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Latency counts edges from the cycle val is presented to the first cycle rdy is seen
    task automatic run_conv(input string tag, input logic [31:0] f, input logic [31:0] exp_int,
                            input logic exp_ovf, input logic exp_nan, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        val    = 1'b1;
        in_f32 = f;
        @(posedge clk); #1;
        val    = 1'b0;
        lat    = 1;
        check_val({tag, ".busy"}, 32'(busy), 32'd1);
        while (!rdy && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, ".out"}, out_int, exp_int);
        check_val({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
        check_val({tag, ".nan"}, 32'(nan), 32'(exp_nan));
        @(posedge clk); #1;
        check_val({tag, ".rdy_pulse"}, 32'(rdy), 32'd0);
        check_val({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check_val({tag, ".hold"}, out_int, exp_int);
    endtask

    initial begin
        int rdy_cnt;
        rst    = 1'b0;
        val    = 1'b0;
        in_f32 = '0;
        #12;
        check_val("rst.busy", 32'(busy), 32'd0);
        check_val("rst.rdy",  32'(rdy),  32'd0);
        check_val("rst.out",  out_int,   32'd0);
        check_val("rst.flags", {30'd0, ovf, nan}, 32'd0);
        #10 rst = 1'b1;

        run_conv("four",     32'h40800000, 32'd4,         1'b0, 1'b0, 23);
        run_conv("m1p5",     32'hBFC00000, 32'hFFFFFFFF,  1'b0, 1'b0, 25);
        run_conv("quarter",  32'h3E800000, 32'd0,         1'b0, 1'b0, 2);
        run_conv("pos_ovf",  32'h4F000000, 32'h7FFFFFFF,  1'b1, 1'b0, 2);
        run_conv("neg_2p31", 32'hCF000000, 32'h80000000,  1'b0, 1'b0, 2);
        run_conv("neg_inf",  32'hFF800000, 32'h80000000,  1'b1, 1'b0, 2);
        run_conv("qnan",     32'h7FC00000, 32'd0,         1'b0, 1'b1, 2);
        run_conv("e23",      32'h4B000001, 32'd8388609,   1'b0, 1'b0, 2);
        run_conv("max_pos",  32'h4EFFFFFF, 32'h7FFFFF80,  1'b0, 1'b0, 9);
        run_conv("max_neg",  32'hCEFFFFFF, 32'h80000080,  1'b0, 1'b0, 9);
        run_conv("pos_inf",  32'h7F800000, 32'h7FFFFFFF,  1'b1, 1'b0, 2);
        run_conv("neg_zero", 32'h80000000, 32'd0,         1'b0, 1'b0, 2);
        run_conv("denorm",   32'h00000001, 32'd0,         1'b0, 1'b0, 2);

        // Second start while busy must be dropped
        @(posedge clk); #1;
        val = 1'b1; in_f32 = 32'h3F800000;
        @(posedge clk); #1;
        val = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        val = 1'b1; in_f32 = 32'h40000000;
        @(posedge clk); #1;
        val = 1'b0;
        rdy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rdy) rdy_cnt++;
        end
        check_val("drop.rdy_cnt", 32'(rdy_cnt), 32'd1);
        check_val("drop.out",     out_int,      32'd1);
        check_val("drop.busy",    32'(busy),    32'd0);

        // Asynchronous reset mid-shift aborts the conversion
        @(posedge clk); #1;
        val = 1'b1; in_f32 = 32'h3F800000;
        @(posedge clk); #1;
        val = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_val("abort.busy", 32'(busy), 32'd0);
        check_val("abort.out",  out_int,   32'd0);
        check_val("abort.rdy",  32'(rdy),  32'd0);
        @(posedge clk); #3 rst = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (rdy) rdy_cnt++;
        end
        check_val("abort.no_rdy", 32'(rdy_cnt), 32'd0);
        run_conv("ten", 32'h41200000, 32'd10, 1'b0, 1'b0, 22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/float2int32_seq.md
Name: float2int32_seq

Overview:
Sequential IEEE-754 single-precision to signed 32-bit integer converter. It is the inverse of int2float32 and uses the same start/ready handshake style as recip_f32. It truncates toward zero and saturates on overflow. The datapath is an iterative one-bit-per-cycle shifter, which keeps area small. It sits on the output side of the divide/reciprocal path, returning PE results to the integer domain.

Parameters:
SAT_POS, 32'h7FFFFFFF, value driven for positive overflow and +inf
SAT_NEG, 32'h80000000, value driven for negative overflow and -inf
NAN_VAL, 32'h00000000, value driven for any NaN input

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
val  in  1  start request; sampled only in IDLE
in_f32  in  32  float operand; captured on an accepted start
busy  out  1  high from the cycle after an accepted start through DONE
rdy  out  1  one-cycle pulse; result valid
out_int  out  32  signed integer result; held until the next rdy
ovf  out  1  saturation occurred (overflow or inf); valid with rdy, held
nan  out  1  NaN input; valid with rdy, held

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, rdy=0, out_int=0, ovf=0, nan=0, internal registers cleared. Reset mid-operation aborts the conversion; no rdy is produced.
- Unpack: s=in_f32[31], E=in_f32[30:23], m={1,in_f32[22:0]} (24-bit), e=E-127 (signed 9-bit).
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On val=1, capture the operand, compute the class and shift count n, and go to SHIFT.
  - val while busy=1 is ignored (not queued).
- Classes (decided at capture, in priority order):
  - E=255 and mantissa!=0: NaN. Result NAN_VAL, nan=1, n=0.
  - E=255 and mantissa=0: inf. Result SAT_POS or SAT_NEG by sign, ovf=1, n=0.
  - e>=31: overflow, ovf=1, n=0, result SAT_POS or SAT_NEG by sign. Exception: in_f32=32'hCF000000 (exactly -2^31) yields 32'h80000000 with ovf=0.
  - e<0, including zero and denormals: result 0, n=0.
  - Otherwise: mag=m zero-extended to 32 bits; n=|e-23|; direction is left if e>23, right if e<23.
- SHIFT:
  - While n>0: mag shifts one bit in the chosen direction; n decrements.
  - When n=0: go to DONE. On that edge out_int = s ? -mag : mag (two's complement); the special-class values are loaded instead where they apply.
- DONE:
  - rdy=1 for exactly one cycle; busy=1; go to IDLE.
  - A val in the same cycle is ignored.
- Latency: rdy is high in the cycle beginning n+2 rising edges after the edge that sampled val.
  - Minimum 2 cycles (special classes, e=23).
  - Maximum 25 cycles (e=0).
- Right shift discards bits, so the magnitude truncates toward zero. -0.0 yields 0.
- out_int, ovf and nan change only on the edge that enters DONE, and hold through IDLE.
- busy=0 only in IDLE. Throughput is one conversion per n+3 cycles; back-to-back starts are possible the cycle after rdy.

Test Plan:
- 32'h40800000 (4.0): out_int=4, ovf=0, nan=0, rdy 23 cycles after start (n=21).
- 32'hBFC00000 (-1.5): out_int=32'hFFFFFFFF (-1). 32'h3E800000 (0.25): out_int=0, rdy at 2 cycles.
- 32'h4F000000 (2^31): out_int=32'h7FFFFFFF, ovf=1. 32'hCF000000: out_int=32'h80000000, ovf=0. 32'hFF800000 (-inf): out_int=32'h80000000, ovf=1.
- 32'h7FC00000 (NaN): out_int=0, nan=1, latency 2. Then 32'h4B000001 (8388609.0, e=23): out_int=8388609, latency 2, nan=0.
- Start 32'h3F800000 (1.0), pulse val again 3 cycles later with 32'h40000000: exactly one rdy, out_int=1; the second request is dropped.
- Start 32'h3F800000, assert rst=0 asynchronously mid-SHIFT (between edges): outputs 0 immediately, no rdy. After release, a new start with 32'h41200000 (10.0) gives out_int=10 at 22 cycles.
